// File: rtl/spi_flash_op_sched.sv
// spi_flash_op_sched: queues erase/program/read requests and sequences the SPI flash
// command stream (WREN, opcode, status polling) for one operation at a time.
module spi_flash_op_sched #(
    parameter logic [23:0] SECTOR_ADDR = 24'h000000,
    parameter int          POLL_GAP    = 500,
    parameter int          TIMEOUT     = 50_000_000
) (
    input  logic        sclk,
    input  logic        rst_n,
    input  logic        flag_erase,
    input  logic        flag_write,
    input  logic        flag_read,
    output logic        spi_start,
    output logic [7:0]  spi_cmd,
    output logic [23:0] spi_addr,
    input  logic        spi_done,
    input  logic [7:0]  spi_rdata,
    output logic        busy,
    output logic        op_done,
    output logic        err
);
    typedef enum logic [3:0] {IDLE, WREN, WREN_W, CMD, CMD_W, GAP, RDSR, RDSR_W, DONE} state_t;
    state_t      state, state_nxt;
    logic [2:0]  pend;
    logic [2:0]  grant_clr;
    logic [7:0]  opc, grant_opc;
    logic [15:0] gap_cnt;
    logic [31:0] to_cnt;
    logic        grant, polling, timeout_hit, wip;
    logic        start_d, busy_d, done_d, err_d;
    logic [7:0]  cmd_d;
    logic [23:0] addr_d;
    // pend bit order is {erase, write, read}, which is also the priority order
    assign grant       = (state == IDLE) && |pend;
    assign grant_opc   = pend[2] ? 8'hD8 : pend[1] ? 8'h02 : 8'h03;
    assign grant_clr   = !grant ? 3'b000 : pend[2] ? 3'b100 : pend[1] ? 3'b010 : 3'b001;
    assign polling     = state inside {GAP, RDSR, RDSR_W};
    assign timeout_hit = polling && (to_cnt == 32'(TIMEOUT - 1));
    assign wip         = (spi_rdata & 8'h01) != 8'h00;
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = !grant ? IDLE : (pend[2] || pend[1]) ? WREN : CMD;
            WREN:    state_nxt = WREN_W;
            WREN_W:  state_nxt = spi_done ? CMD : WREN_W;
            CMD:     state_nxt = CMD_W;
            CMD_W:   state_nxt = !spi_done ? CMD_W : (opc == 8'h03) ? DONE : GAP;
            GAP:     state_nxt = timeout_hit ? DONE : (gap_cnt == 16'd0) ? RDSR : GAP;
            RDSR:    state_nxt = timeout_hit ? DONE : RDSR_W;
            RDSR_W:  state_nxt = timeout_hit ? DONE : !spi_done ? RDSR_W : wip ? GAP : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    // outputs are decoded from the next state so that they can be registered
    always_comb begin
        start_d = state_nxt inside {WREN, CMD, RDSR};
        cmd_d   = (state_nxt == WREN) ? 8'h06 :
                  (state_nxt == CMD)  ? (grant ? grant_opc : opc) :
                  (state_nxt == RDSR) ? 8'h05 : spi_cmd;
        addr_d  = (state_nxt == CMD) ? SECTOR_ADDR : spi_addr;
        busy_d  = state_nxt != IDLE;
        done_d  = state_nxt == DONE;
        err_d   = timeout_hit ? 1'b1 : grant ? 1'b0 : err;
    end
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= '0;
            opc       <= '0;
            gap_cnt   <= '0;
            to_cnt    <= '0;
            spi_start <= 1'b0;
            spi_cmd   <= '0;
            spi_addr  <= '0;
            busy      <= 1'b0;
            op_done   <= 1'b0;
            err       <= 1'b0;
        end else begin
            pend      <= (pend & ~grant_clr) | {flag_erase, flag_write, flag_read};
            opc       <= grant ? grant_opc : opc;
            gap_cnt   <= (state_nxt == GAP && state != GAP) ? 16'(POLL_GAP - 1) :
                         (state == GAP && gap_cnt != 16'd0) ? gap_cnt - 16'd1 : gap_cnt;
            to_cnt    <= (state == CMD_W && state_nxt == GAP) ? 32'd0 :
                         polling ? to_cnt + 32'd1 : to_cnt;
            spi_start <= start_d;
            spi_cmd   <= cmd_d;
            spi_addr  <= addr_d;
            busy      <= busy_d;
            op_done   <= done_d;
            err       <= err_d;
        end
    end
endmodule
